display_feed_controller: RTL and testbench

- Sequences the 4-digit display path of the multiplier. Arbitrates between two binary requesters: operand entry (low priority) and multiplier product (high priority).
- Converts the granted binary value to packed BCD with an iterative double-dabble datapath, one shift per clock.
- Applies saturation and optional leading-zero blanking, then publishes the 16-bit BCD word consumed by display_multiplexer.
- Digit codes 4'hA–4'hF render blank on the display, so 4'hF is the blank digit.

---
 rtl/display_feed_controller_if.sv | 28 ++
 rtl/display_feed_controller.sv | 138 +++++++++++++
 tb/tb_display_feed_controller.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/display_feed_controller_if.sv
// Handshake and display bus between the two binary requesters, the feed controller
// and the display multiplexer.
interface display_feed_controller_if #(
    parameter int BIN_W = 14
);
    logic             op_valid;
    logic [BIN_W-1:0] op_value;
    logic             op_ready;
    logic             res_valid;
    logic [BIN_W-1:0] res_value;
    logic             res_ready;
    logic             blank_en;
    logic [15:0]      BCD_code;
    logic             bcd_valid;
    logic             busy;
    logic             src_is_result;
    logic             overflow;

    modport master (
        output op_valid, op_value, res_valid, res_value, blank_en,
        input  op_ready, res_ready, BCD_code, bcd_valid, busy, src_is_result, overflow
    );

    modport slave (
        input  op_valid, op_value, res_valid, res_value, blank_en,
        output op_ready, res_ready, BCD_code, bcd_valid, busy, src_is_result, overflow
    );
endinterface

// File: rtl/display_feed_controller.sv
// Arbitrates operand/product requests, converts the winner to BCD by serial double-dabble,
// then saturates, optionally blanks leading zeros and publishes the 4-digit word.
module display_feed_controller #(
    parameter int BIN_W       = 14,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input logic                       clk,
    input logic                       reset,
    display_feed_controller_if.slave  bus
);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int ITER_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, PUBLISH} state_t;

    state_t                state, state_nxt;
    logic [ITER_W-1:0]     iter_p0;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [BIN_W-1:0]      bin_p0;
    logic [15:0]           bcd_p0;
    logic [15:0]           bcd_adj;
    logic [16+BIN_W-1:0]   shift_w;
    logic                  src_pend, ovf_pend;
    logic                  grant_res, grant_op;
    logic                  op_ready_c, res_ready_c, busy_c;
    logic [BIN_W-1:0]      grant_value;
    logic [15:0]           bcd_code_p1;
    logic                  vld_p1, src_p1, ovf_p1;

    function automatic logic [BIN_W-1:0] sat_value(input logic [BIN_W-1:0] v);
        return (32'(v) > 32'd9999) ? BIN_W'(9999) : v;
    endfunction

    function automatic logic [15:0] add3_nibbles(input logic [15:0] d);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (d[i*4 +: 4] >= 4'd5) ? d[i*4 +: 4] + 4'd3 : d[i*4 +: 4];
        end
        return r;
    endfunction

    // Units digit stays visible so that zero still shows as a single 0.
    function automatic logic [15:0] blank_leading(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (d[15:12] == 4'd0) begin
            r[15:12] = 4'hF;
            if (d[11:8] == 4'd0) begin
                r[11:8] = 4'hF;
                if (d[7:4] == 4'd0) r[7:4] = 4'hF;
            end
        end
        return r;
    endfunction

    assign bcd_adj     = add3_nibbles(bcd_p0);
    assign shift_w     = {bcd_adj, bin_p0} << 1;
    assign grant_value = grant_res ? bus.res_value : bus.op_value;

    always_comb begin
        state_nxt   = state;
        op_ready_c  = 1'b0;
        res_ready_c = 1'b0;
        busy_c      = 1'b0;
        grant_res   = 1'b0;
        grant_op    = 1'b0;
        case (state)
            IDLE: begin
                res_ready_c = 1'b1;
                op_ready_c  = (hold_cnt == '0) && !bus.res_valid;
                if (bus.res_valid) begin
                    grant_res = 1'b1;
                    state_nxt = CONV;
                end else if (bus.op_valid && op_ready_c) begin
                    grant_op  = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                busy_c = 1'b1;
                if (iter_p0 == ITER_W'(BIN_W - 1)) state_nxt = PUBLISH;
            end
            PUBLISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and published outputs: asynchronous reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            iter_p0     <= '0;
            hold_cnt    <= '0;
            src_pend    <= 1'b0;
            ovf_pend    <= 1'b0;
            bcd_code_p1 <= 16'hFFFF;
            vld_p1      <= 1'b0;
            src_p1      <= 1'b0;
            ovf_p1      <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= (state == PUBLISH);
            if (grant_res || grant_op) begin
                iter_p0  <= '0;
                src_pend <= grant_res;
                ovf_pend <= (32'(grant_value) > 32'd9999);
            end else if (state == CONV) begin
                iter_p0 <= iter_p0 + ITER_W'(1);
            end
            if (state == PUBLISH) begin
                bcd_code_p1 <= bus.blank_en ? blank_leading(bcd_p0) : bcd_p0;
                src_p1      <= src_pend;
                ovf_p1      <= ovf_pend;
            end
            if (state == PUBLISH && src_pend) hold_cnt <= HOLD_W'(HOLD_CYCLES);
            else if (hold_cnt != '0)          hold_cnt <= hold_cnt - HOLD_W'(1);
        end
    end

    // Conversion datapath: meaningful only between a grant and the following publish.
    always_ff @(posedge clk) begin
        if (grant_res || grant_op) begin
            bin_p0 <= sat_value(grant_value);
            bcd_p0 <= '0;
        end else if (state == CONV) begin
            bcd_p0 <= shift_w[16+BIN_W-1:BIN_W];
            bin_p0 <= shift_w[BIN_W-1:0];
        end
    end

    assign bus.op_ready      = op_ready_c;
    assign bus.res_ready     = res_ready_c;
    assign bus.busy          = busy_c;
    assign bus.BCD_code      = bcd_code_p1;
    assign bus.bcd_valid     = vld_p1;
    assign bus.src_is_result = src_p1;
    assign bus.overflow      = ovf_p1;
endmodule

// File: tb/tb_display_feed_controller.sv
// Directed and randomized bench for display_feed_controller with a decimal-arithmetic
// reference model for BCD words and a cycle-count model of the product hold window.
module tb_display_feed_controller;
    localparam int BIN_W = 14;
    localparam int HOLD  = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   c_pub = -1000;

    display_feed_controller_if #(.BIN_W(BIN_W)) bus();

    display_feed_controller #(.BIN_W(BIN_W), .HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_bcd(input int v, input bit blk);
        int s;
        logic [3:0] d3, d2, d1, d0;
        s  = (v > 9999) ? 9999 : v;
        d3 = 4'(s / 1000);
        d2 = 4'((s / 100) % 10);
        d1 = 4'((s / 10) % 10);
        d0 = 4'(s % 10);
        if (blk) begin
            if (s < 1000) d3 = 4'hF;
            if (s < 100)  d2 = 4'hF;
            if (s < 10)   d1 = 4'hF;
        end
        return {d3, d2, d1, d0};
    endfunction

    // Called at a negedge with the controller idle: operands wait HOLD edges after a product publish.
    function automatic logic model_op_ready();
        return ((cyc - c_pub) >= HOLD) && !bus.res_valid;
    endfunction

    task automatic request(input bit is_res, input int val, input bit blk);
        bit acc, rdy;
        int busy_cnt, lat;
        bus.blank_en = blk;
        if (is_res) begin
            bus.res_valid = 1'b1;
            bus.res_value = BIN_W'(val);
        end else begin
            bus.op_valid = 1'b1;
            bus.op_value = BIN_W'(val);
        end
        #1;
        acc = 1'b0;
        for (int n = 0; n < 200; n++) begin
            rdy = is_res ? bus.res_ready : bus.op_ready;
            if (!is_res) check("op_ready_hold", {31'd0, bus.op_ready}, {31'd0, model_op_ready()});
            @(negedge clk);
            if (rdy) begin
                acc = 1'b1;
                break;
            end
            #1;
        end
        if (is_res) bus.res_valid = 1'b0;
        else        bus.op_valid  = 1'b0;
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        busy_cnt = 0;
        lat = -1;
        for (int k = 0; k <= 40; k++) begin
            if (bus.bcd_valid) begin
                lat = k;
                break;
            end
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
        // k counts edges after the accepting edge.
        check("latency", 32'(lat), 32'(BIN_W + 1));
        check("busy_cycles", 32'(busy_cnt), 32'(BIN_W));
        check("bcd_code", {16'd0, bus.BCD_code}, {16'd0, model_bcd(val, blk)});
        check("src_is_result", {31'd0, bus.src_is_result}, {31'd0, is_res});
        check("overflow", {31'd0, bus.overflow}, {31'd0, (val > 9999)});
        if (is_res) c_pub = cyc;
        @(negedge clk);
        check("bcd_valid_pulse", {31'd0, bus.bcd_valid}, 32'd0);
        check("bcd_code_held", {16'd0, bus.BCD_code}, {16'd0, model_bcd(val, blk)});
    endtask

    initial begin
        int pulses;
        int v;
        bit r;
        bus.op_valid  = 1'b0;
        bus.op_value  = '0;
        bus.res_valid = 1'b0;
        bus.res_value = '0;
        bus.blank_en  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_bcd_code", {16'd0, bus.BCD_code}, 32'h0000FFFF);
        check("rst_bcd_valid", {31'd0, bus.bcd_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_src", {31'd0, bus.src_is_result}, 32'd0);
        check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        check("rst_op_ready", {31'd0, bus.op_ready}, 32'd1);
        check("rst_res_ready", {31'd0, bus.res_ready}, 32'd1);
        @(negedge clk);

        // Product then operand blocked by the hold window
        request(1'b1, 1234, 1'b0);
        request(1'b0, 7, 1'b1);

        // Simultaneous requests: product wins, operand waits out the hold
        bus.op_valid  = 1'b1;
        bus.op_value  = BIN_W'(42);
        bus.res_valid = 1'b1;
        bus.res_value = BIN_W'(300);
        #1;
        check("both_op_ready", {31'd0, bus.op_ready}, 32'd0);
        check("both_res_ready", {31'd0, bus.res_ready}, 32'd1);
        request(1'b1, 300, 1'b0);
        request(1'b0, 42, 1'b0);

        // Saturation, then zero with blanking
        request(1'b1, 12000, 1'b0);
        request(1'b0, 0, 1'b1);

        // Reset during the fifth conversion cycle
        bus.blank_en  = 1'b0;
        bus.res_valid = 1'b1;
        bus.res_value = BIN_W'(5678);
        #1;
        check("abort_res_ready", {31'd0, bus.res_ready}, 32'd1);
        @(negedge clk);
        bus.res_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        c_pub = -1000;
        #1;
        check("abort_bcd_code", {16'd0, bus.BCD_code}, 32'h0000FFFF);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_bcd_valid", {31'd0, bus.bcd_valid}, 32'd0);
        check("abort_src", {31'd0, bus.src_is_result}, 32'd0);
        check("abort_ovf", {31'd0, bus.overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.bcd_valid) pulses++;
        end
        check("abort_no_pulse", 32'(pulses), 32'd0);
        check("abort_op_ready", {31'd0, bus.op_ready}, 32'd1);
        request(1'b1, 5678, 1'b0);

        // Randomized requests including decimal boundaries
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 5))
                0: v = 9999;
                1: v = 10000;
                2: v = $urandom_range(0, 9);
                3: v = $urandom_range(10, 999);
                default: v = $urandom_range(0, 16383);
            endcase
            r = 1'($urandom_range(0, 1));
            request(r, v, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
